// File: rtl/cpld_spi_responder_pkg.sv
// Shared constants, FSM encoding and helpers for the CPU-side SPI responder.
package cpld_spi_responder_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_ID      = 3'd1;
  localparam logic [2:0] ADDR_CTRL0   = 3'd2;
  localparam logic [2:0] ADDR_CTRL1   = 3'd3;
  localparam logic [2:0] ADDR_CTRL2   = 3'd4;
  localparam logic [2:0] ADDR_CTRL3   = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH = 3'd6;
  localparam logic [2:0] ADDR_ERR     = 3'd7;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_BITS   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StTail
  } resp_state_e;

  // Write-strobe bit for a control-byte address, zero for any other address.
  function automatic logic [3:0] ctrl_strobe(input logic [2:0] addr);
    logic [3:0] strobe;
    case (addr)
      ADDR_CTRL0: strobe = 4'b0001;
      ADDR_CTRL1: strobe = 4'b0010;
      ADDR_CTRL2: strobe = 4'b0100;
      ADDR_CTRL3: strobe = 4'b1000;
      default:    strobe = 4'b0000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/cpld_spi_responder_if.sv
// SPI pin bundle between a CPU-side initiator and the CPLD responder.
interface cpld_spi_responder_if;
  logic spi_clk;
  logic spi_mosi;
  logic spi_cs_INV;
  logic spi_miso;

  modport master (
    output spi_clk,
    output spi_mosi,
    output spi_cs_INV,
    input  spi_miso
  );

  modport slave (
    input  spi_clk,
    input  spi_mosi,
    input  spi_cs_INV,
    output spi_miso
  );
endinterface

// File: rtl/spi_resp_sync.sv
// Two-flop synchronisers for asynchronous SPI pins plus SCLK and CS edge detection.
module spi_resp_sync (
  input  logic sysclk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_mosi,
  input  logic spi_cs_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi,
  output logic cs_fall,
  output logic cs_rise
);

  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [2:0] cs_q;

  // CS chain resets to "selected" so a CS already low at reset release yields no fall edge.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sclk_q <= '0;
      mosi_q <= '0;
      cs_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      mosi_q <= {mosi_q[0], spi_mosi};
      cs_q   <= {cs_q[1:0], spi_cs_n};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign mosi      = mosi_q[1];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];

endmodule

// File: rtl/cpld_spi_responder.sv
// SPI mode-0 responder exposing status, device ID, control bytes and scratch to the CPU.
// Optional abort counter at address 7 is built when SPI_RESP_ERR_COUNT_EN is defined.
module cpld_spi_responder
  import cpld_spi_responder_pkg::*;
#(
  parameter logic [7:0]  DEVICE_ID  = 8'hA5,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic                 sysclk,
  input  logic                 reset,
  cpld_spi_responder_if.slave  spi,
  input  logic [7:0]           status_in,
  output logic [31:0]          ctrl_out,
  output logic [3:0]           ctrl_wr_strobe,
  output logic                 frame_active
);

  localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
  localparam logic [4:0] CMD_DONE   = 5'(CMD_BITS);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, mosi_s, cs_fall, cs_rise;

  spi_resp_sync u_sync (
    .sysclk    (sysclk),
    .reset     (reset),
    .spi_clk   (spi.spi_clk),
    .spi_mosi  (spi.spi_mosi),
    .spi_cs_n  (spi.spi_cs_INV),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi      (mosi_s),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  resp_state_e state_q;
  logic [4:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic        rw_q;
  logic [2:0]  addr_q;
  logic [6:0]  miso_sr_q;
  logic        miso_q;
  logic        frame_active_q;
  logic [31:0] ctrl_q;
  logic [3:0]  strobe_q;
  logic [7:0]  scratch_q;

  logic [2:0]  rd_addr;
  logic [7:0]  rd_val;
  logic [7:0]  wr_data;
  logic [1:0]  ctrl_idx;
  logic        wr_commit;

`ifdef SPI_RESP_ERR_COUNT_EN
  logic [7:0] err_cnt_q;
  logic       abort;
  logic       err_clr;
`endif

  // Address completes on the 8th rise, so it is assembled from the live shift and MOSI.
  assign rd_addr  = {shift_q[1:0], mosi_s};
  assign wr_data  = {shift_q, mosi_s};
  assign ctrl_idx = 2'(addr_q[1:0] - 2'd2);

  assign wr_commit = (state_q == StData) && sclk_rise && !cs_rise &&
                     (bit_cnt_q == FRAME_LAST) && !rw_q;

  always_comb begin
    rd_val = 8'h00;
    case (rd_addr)
      ADDR_STATUS:  rd_val = status_in;
      ADDR_ID:      rd_val = DEVICE_ID;
      ADDR_CTRL0:   rd_val = ctrl_q[7:0];
      ADDR_CTRL1:   rd_val = ctrl_q[15:8];
      ADDR_CTRL2:   rd_val = ctrl_q[23:16];
      ADDR_CTRL3:   rd_val = ctrl_q[31:24];
      ADDR_SCRATCH: rd_val = scratch_q;
`ifdef SPI_RESP_ERR_COUNT_EN
      ADDR_ERR:     rd_val = err_cnt_q;
`endif
      default:      rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rw_q           <= 1'b0;
      addr_q         <= '0;
      miso_sr_q      <= '0;
      miso_q         <= 1'b0;
      frame_active_q <= 1'b0;
      ctrl_q         <= CTRL_RESET;
      strobe_q       <= '0;
      scratch_q      <= '0;
    end else begin
      strobe_q <= '0;
      // CS release wins over any coincident SCLK edge.
      if (cs_rise) begin
        state_q        <= StIdle;
        frame_active_q <= 1'b0;
        miso_q         <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q        <= StCmd;
              bit_cnt_q      <= '0;
              shift_q        <= '0;
              miso_q         <= 1'b0;
              frame_active_q <= 1'b1;
            end
          end
          StCmd: begin
            if (sclk_rise) begin
              shift_q   <= {shift_q[5:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == CMD_LAST) begin
                rw_q    <= shift_q[6];
                addr_q  <= rd_addr;
                state_q <= StData;
                if (shift_q[6]) begin
                  miso_sr_q <= rd_val[6:0];
                  miso_q    <= rd_val[7];
                end
              end
            end
          end
          StData: begin
            if (sclk_rise) begin
              shift_q   <= {shift_q[5:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == FRAME_LAST) begin
                state_q <= StTail;
                miso_q  <= 1'b0;
              end
            end else if (sclk_fall && rw_q && bit_cnt_q != CMD_DONE) begin
              // Fall right after the 8th rise is skipped: bit 7 must hold through the 9th rise.
              miso_sr_q <= {miso_sr_q[5:0], 1'b0};
              miso_q    <= miso_sr_q[6];
            end
          end
          StTail: begin
            miso_q <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end

      if (wr_commit) begin
        if (|ctrl_strobe(addr_q)) begin
          ctrl_q[{ctrl_idx, 3'b000} +: 8] <= wr_data;
          strobe_q                        <= ctrl_strobe(addr_q);
        end
        if (addr_q == ADDR_SCRATCH) begin
          scratch_q <= wr_data;
        end
      end
    end
  end

`ifdef SPI_RESP_ERR_COUNT_EN
  assign abort   = cs_rise && ((state_q == StCmd) || (state_q == StData));
  assign err_clr = wr_commit && (addr_q == ADDR_ERR);

  always_ff @(posedge sysclk) begin
    if (reset || err_clr) begin
      err_cnt_q <= '0;
    end else if (abort && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

  assign spi.spi_miso   = miso_q;
  assign ctrl_out       = ctrl_q;
  assign ctrl_wr_strobe = strobe_q;
  assign frame_active   = frame_active_q;

endmodule
